// File: rtl/riscv_alu_pkg.sv
// Shared types and op-code helpers for the sequential RISC-V ALU.
package riscv_alu_pkg;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_SLTU   = 5'b00011,
    OP_SUB    = 5'b00110,
    OP_SLT    = 5'b00111,
    OP_SRL    = 5'b01000,
    OP_SLL    = 5'b01001,
    OP_SRA    = 5'b01010,
    OP_XOR    = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  function automatic logic is_iterative(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/riscv_alu_if.sv
// Request/response handshake bundle between operand fetch, the ALU and writeback.
interface riscv_alu_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      alu_op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, op1, op2, alu_op, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, op1, op2, alu_op, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );

endinterface

// File: rtl/riscv_muldiv_iter.sv
// Iterative multiply / restoring divide engine sharing one accumulator and shift register.
// Divide step logic only exists when RISCV_ALU_DIV_EN is defined.
module riscv_muldiv_iter
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            div,
  input  logic [1:0]      op_lo,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] ITER_N = CNT_W'(XLEN);

  logic [XLEN-1:0]   acc_q, sreg_q, mcand_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, div_q, neg_q;
  logic [1:0]        op_lo_q;

  logic              signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   acc_nx, sreg_nx;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   mul_res, div_res;

  // Division signedness lives in bit 0 (DIV/REM signed); multiply in bits 1:0.
  assign signed_a = div ? ~op_lo[0] : (op_lo != 2'b11);
  assign signed_b = div ? ~op_lo[0] : ~op_lo[1];
  assign neg_a    = signed_a & op1[XLEN-1];
  assign neg_b    = signed_b & op2[XLEN-1];
  assign mag_a    = neg_a ? -op1 : op1;
  assign mag_b    = neg_b ? -op2 : op2;

`ifdef RISCV_ALU_DIV_EN
  logic            neg_rem_q;
  logic [XLEN:0]   trial, diff;
  logic [XLEN-1:0] quo, rem;
`endif

  always_comb begin
    sum     = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, mcand_q} : '0);
    acc_nx  = sum[XLEN:1];
    sreg_nx = {sum[0], sreg_q[XLEN-1:1]};
`ifdef RISCV_ALU_DIV_EN
    trial = {acc_q, sreg_q[XLEN-1]};
    diff  = trial - {1'b0, mcand_q};
    if (div_q) begin
      acc_nx  = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      sreg_nx = {sreg_q[XLEN-2:0], ~diff[XLEN]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sreg_q    <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      op_lo_q   <= '0;
`ifdef RISCV_ALU_DIV_EN
      neg_rem_q <= 1'b0;
`endif
    end else if (start) begin
      acc_q     <= '0;
      sreg_q    <= div ? mag_a : mag_b;
      mcand_q   <= div ? mag_b : mag_a;
      cnt_q     <= ITER_N;
      busy_q    <= 1'b1;
      div_q     <= div;
      neg_q     <= neg_a ^ neg_b;
      op_lo_q   <= op_lo;
`ifdef RISCV_ALU_DIV_EN
      neg_rem_q <= neg_a;
`endif
    end else if (busy_q) begin
      acc_q  <= acc_nx;
      sreg_q <= sreg_nx;
      cnt_q  <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  // The last step's next-state values are handed out directly so the result
  // lands on the same edge as the final iteration.
  assign done     = busy_q && (cnt_q == CNT_W'(1));
  assign prod     = {acc_nx, sreg_nx};
  assign prod_fix = neg_q ? -prod : prod;
  assign mul_res  = (op_lo_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

`ifdef RISCV_ALU_DIV_EN
  assign quo     = neg_q ? -sreg_nx : sreg_nx;
  assign rem     = neg_rem_q ? -acc_nx : acc_nx;
  assign div_res = op_lo_q[1] ? rem : quo;
`else
  assign div_res = '0;
`endif

  assign res = div_q ? div_res : mul_res;

endmodule

// File: rtl/riscv_alu_seq.sv
// Multi-cycle RV32I/RV64I ALU with iterative M-extension behind valid/ready handshakes.
// Define RISCV_ALU_DIV_EN to build the divider; otherwise DIV/DIVU/REM/REMU report illegal.
module riscv_alu_seq
  import riscv_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic       clk,
  input logic       rst_n,
  riscv_alu_if.slave bus
);

  // state | meaning
  // IDLE  | no result held, ready for a new op
  // CALC  | multiply/divide iterating, one bit per cycle
  // DONE  | result held on the output until out_ready

`ifdef RISCV_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  alu_state_e        state_q, state_nx;
  logic [4:0]        op;
  logic              accept, div_op, iter_op, iter_done;
  logic              sc_illegal;
  logic [XLEN-1:0]   sc_result, iter_res;
  logic [SHAMT_W-1:0] shamt;

  assign op     = bus.alu_op;
  assign shamt  = bus.op2[SHAMT_W-1:0];
  assign div_op = DIV_EN && is_div(op);
  // Divide by zero is resolved on the single-cycle path without touching the engine.
  assign iter_op = is_iterative(op) && (!is_div(op) || (div_op && (bus.op2 != '0)));

  assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (op)
      OP_AND:  sc_result = bus.op1 & bus.op2;
      OP_OR:   sc_result = bus.op1 | bus.op2;
      OP_XOR:  sc_result = bus.op1 ^ bus.op2;
      OP_ADD:  sc_result = bus.op1 + bus.op2;
      OP_SUB:  sc_result = bus.op1 - bus.op2;
      OP_SLTU: sc_result = {{(XLEN-1){1'b0}}, (bus.op1 < bus.op2)};
      OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
      OP_SRL:  sc_result = bus.op1 >> shamt;
      OP_SLL:  sc_result = bus.op1 << shamt;
      OP_SRA:  sc_result = $signed(bus.op1) >>> shamt;
      OP_DIV, OP_DIVU: begin
        if (DIV_EN) sc_result = '1;
        else        sc_illegal = 1'b1;
      end
      OP_REM, OP_REMU: begin
        if (DIV_EN) sc_result = bus.op1;
        else        sc_illegal = 1'b1;
      end
      default: sc_illegal = 1'b1;
    endcase
  end

  riscv_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && iter_op),
    .div   (div_op),
    .op_lo (op[1:0]),
    .op1   (bus.op1),
    .op2   (bus.op2),
    .done  (iter_done),
    .res   (iter_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_nx = iter_op ? ST_CALC : ST_DONE;
      ST_CALC: if (iter_done) state_nx = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          if (accept) state_nx = iter_op ? ST_CALC : ST_DONE;
          else        state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result  <= '0;
      bus.zero    <= 1'b0;
      bus.illegal <= 1'b0;
    end else if (iter_done) begin
      bus.result  <= iter_res;
      bus.zero    <= (iter_res == '0);
      bus.illegal <= 1'b0;
    end else if (accept && !iter_op) begin
      bus.result  <= sc_result;
      bus.zero    <= (sc_result == '0);
      bus.illegal <= sc_illegal;
    end
  end

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Self-checking bench for riscv_alu_seq (XLEN=32): directed table, random ops vs. arithmetic model, handshake corners.
module tb_riscv_alu_seq;

`ifdef RISCV_ALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_alu_if #(.XLEN(32)) bus ();

  riscv_alu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          ill;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ill, output int lat);
    longint sa, sb, sp;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = '0; ill = 1'b0; lat = 1; p = '0; sp = 0;
    case (op)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00010: r = a + b;
      5'b00011: r = (a < b) ? 32'd1 : 32'd0;
      5'b00110: r = a - b;
      5'b00111: r = (sa < sb) ? 32'd1 : 32'd0;
      5'b01000: r = a >> b[4:0];
      5'b01001: r = a << b[4:0];
      5'b01010: begin sp = sa >>> b[4:0]; p = sp; r = p[31:0]; end
      5'b01101: r = a ^ b;
      5'b10000: begin sp = sa * sb; p = sp; r = p[31:0]; lat = 33; end
      5'b10001: begin sp = sa * sb; p = sp; r = p[63:32]; lat = 33; end
      5'b10010: begin sp = sa * longint'(ub); p = sp; r = p[63:32]; lat = 33; end
      5'b10011: begin p = ua * ub; r = p[63:32]; lat = 33; end
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        if (!DIV_ON) ill = 1'b1;
        else if (b == 32'd0) r = op[1] ? a : 32'hFFFF_FFFF;
        else begin
          lat = 33;
          case (op[1:0])
            2'b00: begin sp = sa / sb; p = sp; end
            2'b01: p = ua / ub;
            2'b10: begin sp = sa % sb; p = sp; end
            default: p = ua % ub;
          endcase
          r = p[31:0];
        end
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Present one op while idle, scramble the inputs after accept, wait for out_valid, then release.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic ill, output int lat);
    bus.in_valid  = 1'b1;
    bus.alu_op    = op;
    bus.op1       = a;
    bus.op2       = b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op1      = $urandom;
    bus.op2      = $urandom;
    bus.alu_op   = 5'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    r   = bus.result;
    z   = bus.zero;
    ill = bus.illegal;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic vec_t mkv(input string n, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] r, input bit ill, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = r; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[14];
  logic [4:0] legal_ops[18] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00110, 5'b00111,
                                5'b01000, 5'b01001, 5'b01010, 5'b01101, 5'b10000, 5'b10001,
                                5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

  initial begin
    logic [31:0] r, er;
    logic z, ill;
    bit eill;
    int lat, elat, spurious;
    logic [4:0] op;
    logic [31:0] a, b;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op1 = '0; bus.op2 = '0; bus.alu_op = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset result", bus.result, 0);
    chk("reset zero", bus.zero, 0);
    chk("reset illegal", bus.illegal, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = mkv("add_wrap", 5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
    vecs[1]  = mkv("sra", 5'b01010, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 1);
    vecs[2]  = mkv("mulh_min", 5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 33);
    vecs[3]  = mkv("mulhsu", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33);
    vecs[4]  = mkv("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF,
                   DIV_ON ? 32'h8000_0000 : 32'd0, !DIV_ON, DIV_ON ? 33 : 1);
    vecs[5]  = mkv("rem_neg", 5'b10110, 32'hFFFF_FFF9, 32'd2,
                   DIV_ON ? 32'hFFFF_FFFF : 32'd0, !DIV_ON, DIV_ON ? 33 : 1);
    vecs[6]  = mkv("divu_by0", 5'b10101, 32'd1234, 32'd0, DIV_ON ? 32'hFFFF_FFFF : 32'd0, !DIV_ON, 1);
    vecs[7]  = mkv("remu_by0", 5'b10111, 32'd5, 32'd0, DIV_ON ? 32'd5 : 32'd0, !DIV_ON, 1);
    vecs[8]  = mkv("illegal_1f", 5'b11111, 32'd9, 32'd3, 32'd0, 1, 1);
    vecs[9]  = mkv("slt_neg", 5'b00111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1);
    vecs[10] = mkv("sltu_big", 5'b00011, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
    vecs[11] = mkv("sub_wrap", 5'b00110, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 1);
    vecs[12] = mkv("mul_m1", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 33);
    vecs[13] = mkv("sll_shamt", 5'b01001, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 0, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, ill, lat);
      chk({vecs[i].name, " result"}, r, vecs[i].res);
      chk({vecs[i].name, " zero"}, z, (vecs[i].res == 32'd0));
      chk({vecs[i].name, " illegal"}, ill, vecs[i].ill);
      chk({vecs[i].name, " latency"}, lat, vecs[i].lat);
    end

    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 17)];
      a  = rand_opnd();
      b  = rand_opnd();
      ref_alu(op, a, b, er, eill, elat);
      run_op(op, a, b, r, z, ill, lat);
      if (r !== er || ill !== eill || lat != elat)
        $display("  random op=%b a=%h b=%h", op, a, b);
      chk("rand result", r, er);
      chk("rand zero", z, (er == 32'd0));
      chk("rand illegal", ill, eill);
      chk("rand latency", lat, elat);
    end

    // Backpressure: hold a result, then release with a new op on the same edge.
    bus.in_valid = 1'b1; bus.alu_op = 5'b00010; bus.op1 = 32'd3; bus.op2 = 32'd4;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op1 = $urandom; bus.op2 = $urandom;
    chk("bp out_valid", bus.out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp result stable", bus.result, 32'd7);
      chk("bp in_ready low", bus.in_ready, 0);
      chk("bp out_valid held", bus.out_valid, 1);
    end
    bus.in_valid = 1'b1; bus.alu_op = 5'b01101; bus.op1 = 32'hA5A5_A5A5; bus.op2 = 32'hFFFF_FFFF;
    bus.out_ready = 1'b1;
    #1;
    chk("release in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    chk("b2b out_valid", bus.out_valid, 1);
    chk("b2b result", bus.result, 32'h5A5A_5A5A);
    bus.alu_op = 5'b10011; bus.op1 = 32'hFFFF_FFFF; bus.op2 = 32'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op1 = $urandom; bus.op2 = $urandom;
    chk("b2b calc out_valid", bus.out_valid, 0);
    chk("b2b calc in_ready", bus.in_ready, 0);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b mulhu latency", lat, 33);
    chk("b2b mulhu result", bus.result, 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of an iterative op.
    bus.in_valid = 1'b1; bus.alu_op = DIV_ON ? 5'b10100 : 5'b10011;
    bus.op1 = 32'd1000; bus.op2 = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midcalc rst out_valid", bus.out_valid, 0);
    chk("midcalc rst in_ready", bus.in_ready, 1);
    chk("midcalc rst result", bus.result, 0);
    chk("midcalc rst zero", bus.zero, 0);
    chk("midcalc rst illegal", bus.illegal, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) spurious++;
    end
    chk("post rst no stale result", spurious, 0);
    ref_alu(5'b10101, 32'd100, 32'd7, er, eill, elat);
    run_op(5'b10101, 32'd100, 32'd7, r, z, ill, lat);
    chk("post rst divu result", r, er);
    chk("post rst divu illegal", ill, eill);
    chk("post rst divu latency", lat, elat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
